// File: rtl/sha256_round_engine_if.sv
// sha256_round_engine_if
//   Bundles the block handshake, the W+K beat stream and the digest result of
//   sha256_round_engine.
//   master : block controller / W+K producer side (drives start, hash_in, wk_*)
//   slave  : the round engine (drives wk_ready, busy, done, hash_out)
//   Signals:
//     start     begin a block (engine samples it only while idle)
//     hash_in   initial a..h, [255:224]=a ... [31:0]=h
//     wk_valid  wk_data carries the next UNROLL W[t]+K[t] words
//     wk_ready  engine accepts a beat this cycle
//     wk_data   lane i at [32i+31:32i] is round t+i (lane 0 earliest)
//     busy      block in progress
//     done      one-cycle pulse, hash_out valid from this cycle on
//     hash_out  result, same packing as hash_in
interface sha256_round_engine_if #(
   parameter int UNROLL = 1
);
   logic                   start;
   logic [255:0]           hash_in;
   logic                   wk_valid;
   logic                   wk_ready;
   logic [32*UNROLL-1:0]   wk_data;
   logic                   busy;
   logic                   done;
   logic [255:0]           hash_out;

   modport master (
      output start, hash_in, wk_valid, wk_data,
      input  wk_ready, busy, done, hash_out
   );

   modport slave (
      input  start, hash_in, wk_valid, wk_data,
      output wk_ready, busy, done, hash_out
   );
endinterface

// File: rtl/sha256_round_engine.sv
// sha256_round_engine
//   Iterative SHA-256 compression of one 512-bit block. a..h live in working
//   registers; each accepted W+K beat applies UNROLL chained rounds. After the
//   last beat the result (optionally fed forward with the initial state) is
//   registered into hash_out and done pulses for one cycle.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous reset, active high
//     bus  sha256_round_engine_if.slave (start/hash_in, wk_valid/wk_ready/
//          wk_data, busy, done, hash_out)
//   Parameters:
//     UNROLL   rounds per beat (1,2,4,8); must divide ROUNDS
//     ROUNDS   rounds per block (64 for real SHA-256)
//     FEED_FWD 1: hash_out = init + working words; 0: working words only
//   The interface instance must be built with the same UNROLL.

// One SHA-256 round. State is packed [7]=a ... [0]=h so that it lines up
// with the 256-bit hash_in/hash_out packing.
module sha256_round (
   input  logic [7:0][31:0] st_i,
   input  logic [31:0]      wk_i,
   output logic [7:0][31:0] st_o
);
   logic [31:0] a, b, c, d, e, f, g, h;
   logic [31:0] s0, s1, ch, maj, t1, t2;

   always_comb begin
      {a, b, c, d, e, f, g, h} = st_i;
      s0   = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
      s1   = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
      ch   = (e & f) ^ (~e & g);
      maj  = (a & b) ^ (a & c) ^ (b & c);
      t1   = h + s1 + ch + wk_i;
      t2   = s0 + maj;
      st_o = {t1 + t2, a, b, c, d + t1, e, f, g};
   end
endmodule

module sha256_round_engine #(
   parameter int UNROLL   = 1,
   parameter int ROUNDS   = 64,
   parameter int FEED_FWD = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   sha256_round_engine_if.slave  bus
);
   localparam int CNT_W = $clog2(ROUNDS) + 1;
   localparam logic [CNT_W-1:0] STEP = CNT_W'(UNROLL);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - UNROLL);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8) ||
       (ROUNDS % UNROLL) != 0) begin : g_param_err
      $error("sha256_round_engine: UNROLL must be 1/2/4/8 and divide ROUNDS");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL, S_DONE} state_e;

   state_e                 state_q, state_d;
   logic [7:0][31:0]       work_q, work_d;
   logic [7:0][31:0]       init_q, init_d;
   logic [CNT_W-1:0]       round_cnt_q, round_cnt_d;
   logic [7:0][31:0]       hash_out_q, hash_out_d;
   logic                   wk_ready, busy, done;

   // Round chain: stage 0 is the current working state, stage UNROLL the
   // state after this beat's rounds.
   logic [UNROLL:0][7:0][31:0] chain;
   assign chain[0] = work_q;

   for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
      sha256_round u_rnd (
         .st_i (chain[i]),
         .wk_i (bus.wk_data[32*i +: 32]),
         .st_o (chain[i+1])
      );
   end

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      init_d      = init_q;
      round_cnt_d = round_cnt_q;
      hash_out_d  = hash_out_q;
      wk_ready    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               work_d      = bus.hash_in;
               init_d      = bus.hash_in;
               round_cnt_d = '0;
               state_d     = S_RUN;
            end
         end
         S_RUN: begin
            wk_ready = 1'b1;
            busy     = 1'b1;
            if (bus.wk_valid) begin
               work_d      = chain[UNROLL];
               round_cnt_d = round_cnt_q + STEP;
               if (round_cnt_q == LAST) state_d = S_FINAL;
            end
         end
         S_FINAL: begin
            busy = 1'b1;
            for (int w = 0; w < 8; w++) begin
               hash_out_d[w] = (FEED_FWD != 0) ? init_q[w] + work_q[w] : work_q[w];
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         work_q      <= '0;
         init_q      <= '0;
         round_cnt_q <= '0;
         hash_out_q  <= '0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         init_q      <= init_d;
         round_cnt_q <= round_cnt_d;
         hash_out_q  <= hash_out_d;
      end
   end

   assign bus.wk_ready = wk_ready;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.hash_out = hash_out_q;
endmodule

// File: tb/tb_sha256_round_engine.sv
module tb_sha256_round_engine;
   localparam logic [255:0] IV =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] DIG_ABC =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_EMPTY =
      256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [0:63][31:0] K = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   logic [0:63][31:0] wk_abc, wk_empty;
   logic [255:0] ref_iv0;

   always #5 clk = ~clk;

   sha256_round_engine_if #(.UNROLL(1)) u1 ();
   sha256_round_engine_if #(.UNROLL(4)) u4 ();
   sha256_round_engine_if #(.UNROLL(1)) u0 ();

   sha256_round_engine #(.UNROLL(1), .ROUNDS(64), .FEED_FWD(1)) dut1 (.clk(clk), .rst(rst), .bus(u1));
   sha256_round_engine #(.UNROLL(4), .ROUNDS(64), .FEED_FWD(1)) dut4 (.clk(clk), .rst(rst), .bus(u4));
   sha256_round_engine #(.UNROLL(1), .ROUNDS(64), .FEED_FWD(0)) dut0 (.clk(clk), .rst(rst), .bus(u0));

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Message schedule plus round constants for one padded block.
   function automatic logic [0:63][31:0] make_wk(input logic [511:0] blk);
      logic [0:63][31:0] w, r;
      for (int t = 0; t < 64; t++) begin
         if (t < 16) w[t] = blk[511 - 32*t -: 32];
         else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
                     (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
         r[t] = w[t] + K[t];
      end
      return r;
   endfunction

   // Reference: n rounds with all W+K words zero, no feed-forward.
   function automatic logic [255:0] ref_zero_rounds(input logic [255:0] init, input int n);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = init;
      for (int r = 0; r < n; r++) begin
         t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g));
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1;
         d = c; c = b; b = a; a = t1 + t2;
      end
      return {a, b, c, d, e, f, g, h};
   endfunction

   // Drives one "abc" block through dut1. stop_beat: return once that many
   // beats were accepted; start_beat: pulse start while in RUN at that beat;
   // poke_done: also drive start during the done cycle.
   task automatic run1(input bit stall, input int start_beat, input bit poke_done, input int stop_beat,
                       output int done_cyc, output int n_done, output logic [255:0] dig,
                       output int stalls, output int beats, output logic [255:0] h1);
      done_cyc = -1; n_done = 0; dig = '0; stalls = 0; beats = 0; h1 = '0;
      u1.hash_in = IV;
      u1.start = 1'b1;
      @(posedge clk); #1;
      u1.start = 1'b0;
      for (int cyc = 1; cyc < 300; cyc++) begin
         logic v, rdy;
         if (beats == stop_beat) return;
         if (cyc == 1) h1 = u1.hash_out;
         v = (beats < 64) && !(stall && ($urandom_range(0, 99) < 30));
         u1.wk_valid = v;
         u1.wk_data = (beats < 64) ? wk_abc[beats] : 32'h0;
         u1.start = (beats == start_beat) || (u1.done && poke_done);
         if (u1.done) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               dig = u1.hash_out;
            end
         end
         rdy = u1.wk_ready;
         if (rdy && !v) stalls++;
         @(posedge clk);
         if (v && rdy) beats++;
         #1;
         if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      end
      u1.wk_valid = 1'b0;
      u1.start = 1'b0;
   endtask

   task automatic run0(input logic [255:0] hin, output int done_cyc, output logic [255:0] dig);
      int beats;
      done_cyc = -1; dig = '0; beats = 0;
      u0.hash_in = hin;
      u0.start = 1'b1;
      @(posedge clk); #1;
      u0.start = 1'b0;
      for (int cyc = 1; cyc < 200 && done_cyc < 0; cyc++) begin
         logic v, rdy;
         v = beats < 64;
         u0.wk_valid = v;
         u0.wk_data = 32'h0;
         if (u0.done) begin
            done_cyc = cyc;
            dig = u0.hash_out;
         end
         rdy = u0.wk_ready;
         @(posedge clk);
         if (v && rdy) beats++;
         #1;
      end
      u0.wk_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({u1.wk_ready, u1.busy, u1.done, u4.wk_ready, u4.busy, u4.done, u0.wk_ready, u0.busy, u0.done} !== 9'b0) begin
         bad++; $display("FAIL reset_ctl: got %b required 0",
            {u1.wk_ready, u1.busy, u1.done, u4.wk_ready, u4.busy, u4.done, u0.wk_ready, u0.busy, u0.done});
      end
      total++;
      if ({u1.hash_out, u4.hash_out, u0.hash_out} !== 768'b0) begin
         bad++; $display("FAIL reset_hash: got %h required 0", u1.hash_out);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if (u1.wk_ready !== 1'b0 || u1.busy !== 1'b0) begin
         bad++; $display("FAIL idle_no_ready: ready=%b busy=%b required 0", u1.wk_ready, u1.busy);
      end
   endtask

   task automatic test_abc();
      int dc, nd, st, bt; logic [255:0] dg, h1;
      run1(1'b0, -1, 1'b0, 1000, dc, nd, dg, st, bt, h1);
      total++;
      if (dg !== DIG_ABC) begin bad++; $display("FAIL abc_digest: got %h required %h", dg, DIG_ABC); end
      total++;
      if (dc !== 66) begin bad++; $display("FAIL abc_done_cycle: got %0d required 66", dc); end
      total++;
      if (nd !== 1) begin bad++; $display("FAIL abc_done_count: got %0d required 1", nd); end
   endtask

   task automatic test_unroll4();
      int dc, beats; logic [255:0] dg;
      dc = -1; beats = 0; dg = '0;
      u4.hash_in = IV;
      u4.start = 1'b1;
      @(posedge clk); #1;
      u4.start = 1'b0;
      for (int cyc = 1; cyc < 100 && dc < 0; cyc++) begin
         logic v, rdy;
         v = beats < 16;
         u4.wk_valid = v;
         u4.wk_data = '0;
         if (v) u4.wk_data = {wk_empty[4*beats+3], wk_empty[4*beats+2], wk_empty[4*beats+1], wk_empty[4*beats]};
         if (u4.done) begin dc = cyc; dg = u4.hash_out; end
         rdy = u4.wk_ready;
         @(posedge clk);
         if (v && rdy) beats++;
         #1;
      end
      u4.wk_valid = 1'b0;
      total++;
      if (dg !== DIG_EMPTY) begin bad++; $display("FAIL u4_digest: got %h required %h", dg, DIG_EMPTY); end
      total++;
      if (dc !== 18) begin bad++; $display("FAIL u4_done_cycle: got %0d required 18", dc); end
   endtask

   task automatic test_stall();
      int dc, nd, st, bt; logic [255:0] dg, h1;
      run1(1'b1, -1, 1'b0, 1000, dc, nd, dg, st, bt, h1);
      total++;
      if (h1 !== DIG_ABC) begin bad++; $display("FAIL hold_across_start: got %h required %h", h1, DIG_ABC); end
      total++;
      if (dg !== DIG_ABC) begin bad++; $display("FAIL stall_digest: got %h required %h", dg, DIG_ABC); end
      total++;
      if (st == 0 || dc !== 66 + st) begin bad++; $display("FAIL stall_done_cycle: got %0d required %0d (stalls %0d)", dc, 66 + st, st); end
      total++;
      if (bt !== 64) begin bad++; $display("FAIL stall_beats: got %0d required 64", bt); end
   endtask

   task automatic test_start_ignored();
      int dc, nd, st, bt; logic [255:0] dg, h1;
      run1(1'b0, 10, 1'b1, 1000, dc, nd, dg, st, bt, h1);
      total++;
      if (dg !== DIG_ABC) begin bad++; $display("FAIL ign_digest: got %h required %h", dg, DIG_ABC); end
      total++;
      if (nd !== 1 || dc !== 66) begin bad++; $display("FAIL ign_done: count %0d cycle %0d required 1 and 66", nd, dc); end
      total++;
      if (u1.busy !== 1'b0 || u1.wk_ready !== 1'b0) begin bad++; $display("FAIL ign_idle_after: busy=%b ready=%b required 0", u1.busy, u1.wk_ready); end
   endtask

   task automatic test_reset_mid_block();
      int dc, nd, st, bt; logic [255:0] dg, h1;
      run1(1'b0, -1, 1'b0, 30, dc, nd, dg, st, bt, h1);
      u1.wk_valid = 1'b1;
      u1.wk_data = 32'hdeadbeef;
      rst = 1'b1;
      #1;
      total++;
      if ({u1.wk_ready, u1.busy, u1.done} !== 3'b0 || u1.hash_out !== 256'b0) begin
         bad++; $display("FAIL midrst_outputs: ctl=%b hash=%h required 0", {u1.wk_ready, u1.busy, u1.done}, u1.hash_out);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         total++;
         if (u1.wk_ready !== 1'b0 || u1.busy !== 1'b0) begin
            bad++; $display("FAIL midrst_no_ready: ready=%b busy=%b required 0", u1.wk_ready, u1.busy);
         end
      end
      u1.wk_valid = 1'b0;
      run1(1'b0, -1, 1'b0, 1000, dc, nd, dg, st, bt, h1);
      total++;
      if (dg !== DIG_ABC || dc !== 66) begin bad++; $display("FAIL midrst_rerun: got %h cycle %0d required %h cycle 66", dg, dc, DIG_ABC); end
   endtask

   task automatic test_no_feed_fwd();
      int dc; logic [255:0] dg;
      run0(256'h0, dc, dg);
      total++;
      if (dg !== 256'h0 || dc !== 66) begin bad++; $display("FAIL nff_zero: got %h cycle %0d required 0 cycle 66", dg, dc); end
      run0(IV, dc, dg);
      total++;
      if (dg !== ref_iv0 || dc !== 66) begin bad++; $display("FAIL nff_iv: got %h cycle %0d required %h cycle 66", dg, dc, ref_iv0); end
   endtask

   initial begin
      {u1.start, u1.wk_valid} = 2'b0; u1.hash_in = '0; u1.wk_data = '0;
      {u4.start, u4.wk_valid} = 2'b0; u4.hash_in = '0; u4.wk_data = '0;
      {u0.start, u0.wk_valid} = 2'b0; u0.hash_in = '0; u0.wk_data = '0;
      wk_abc   = make_wk({32'h61626380, 448'h0, 32'h00000018});
      wk_empty = make_wk({32'h80000000, 480'h0});
      ref_iv0  = ref_zero_rounds(IV, 64);
      test_reset();
      test_abc();
      test_unroll4();
      test_stall();
      test_start_ignored();
      test_reset_mid_block();
      test_no_feed_fwd();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
